// File: rtl/dmac_xfer_ctrl.sv
// Two-channel DMA transfer controller: arbitrates requests and runs
// one read/write/update unit per pass on the shared bus master.
module dmac_xfer_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [31:0] SAR0,
  input  logic [31:0] DAR0,
  input  logic [31:0] SAR1,
  input  logic [31:0] DAR1,
  input  logic [23:0] TCR0,
  input  logic [23:0] TCR1,
  input  logic [1:0]  DE,
  input  logic [1:0]  IE,
  input  logic [1:0]  TE,
  input  logic [1:0]  AR,
  input  logic [1:0]  SM0,
  input  logic [1:0]  DM0,
  input  logic [1:0]  SM1,
  input  logic [1:0]  DM1,
  input  logic [1:0]  TS0,
  input  logic [1:0]  TS1,
  input  logic        DME,
  input  logic        PR,
  input  logic        NMIF,
  input  logic        AE,
  input  logic [1:0]  DREQ,
  output logic [31:0] BUS_A,
  output logic [31:0] BUS_DO,
  input  logic [31:0] BUS_DI,
  output logic [3:0]  BUS_BA,
  output logic        BUS_WE,
  output logic        BUS_REQ,
  input  logic        BUS_BUSY,
  output logic [1:0]  UPD,
  output logic [31:0] SAR_NEW,
  output logic [31:0] DAR_NEW,
  output logic [23:0] TCR_NEW,
  output logic [1:0]  TE_SET,
  output logic [1:0]  IRQ,
  output logic        ACT
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_UPD
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        ch;
  logic        last_srv;
  logic [31:0] data;
  logic        grant;
  logic [1:0]  req;
  logic        pref;
  logic        win;
  logic [31:0] sar;
  logic [31:0] dar;
  logic [23:0] tcr;
  logic [23:0] tcr_new;
  logic [1:0]  sm;
  logic [1:0]  dm;
  logic [1:0]  ts;
  logic [31:0] rd_rep;

  function automatic logic [3:0] lanes(
    input logic [1:0] t,
    input logic [1:0] a
  );
    logic [3:0] l;
    l = 4'b1111;
    unique case (1'b1)
      (t == 2'b00): l = 4'b0001 << (2'd3 - a);
      (t == 2'b01): l = a[1] ? 4'b0011 : 4'b1100;
      default:      l = 4'b1111;
    endcase
    return l;
  endfunction

  // Pick the addressed lane out of the read word, then fan it out.
  function automatic logic [31:0] rep(
    input logic [1:0]  t,
    input logic [1:0]  a,
    input logic [31:0] di
  );
    logic [31:0] sh;
    logic [15:0] h;
    logic [31:0] r;
    sh = di >> {(2'd3 - a), 3'b000};
    h  = a[1] ? di[15:0] : di[31:16];
    r  = di;
    unique case (1'b1)
      (t == 2'b00): r = {4{sh[7:0]}};
      (t == 2'b01): r = {2{h}};
      default:      r = di;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] step_addr(
    input logic [1:0]  md,
    input logic [1:0]  t,
    input logic [31:0] a
  );
    logic [31:0] st;
    logic [31:0] r;
    st = (t == 2'b00) ? 32'd1 :
         (t == 2'b01) ? 32'd2 : 32'd4;
    r = a;
    unique case (1'b1)
      (md == 2'b01): r = a + st;
      (md == 2'b10): r = a - st;
      default:       r = a;
    endcase
    return r;
  endfunction

  assign req = DE & AR | DE & DREQ;

  logic [1:0] req_ok;
  assign req_ok = req & ~TE &
                  {2{DME & ~NMIF & ~AE}};

  assign pref = PR ? ~last_srv : 1'b0;
  assign win  = req_ok[pref] ? pref : ~pref;

  assign sar = ch ? SAR1 : SAR0;
  assign dar = ch ? DAR1 : DAR0;
  assign tcr = ch ? TCR1 : TCR0;
  assign sm  = ch ? SM1 : SM0;
  assign dm  = ch ? DM1 : DM0;
  assign ts  = ch ? TS1 : TS0;

  assign tcr_new = tcr - 24'd1;
  assign rd_rep  = rep(ts, sar[1:0], BUS_DI);
  assign ACT     = (state != ST_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      ch       <= 1'b0;
      last_srv <= 1'b1;
      data     <= 32'd0;
    end else if (CE) begin
      state <= state_nx;
      if (grant) begin
        ch       <= win;
        last_srv <= win;
      end
      if (state == ST_RD && !BUS_BUSY)
        data <= rd_rep;
    end
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    BUS_REQ  = 1'b0;
    BUS_WE   = 1'b0;
    BUS_A    = 32'd0;
    BUS_BA   = 4'd0;
    BUS_DO   = 32'd0;
    UPD      = 2'b00;
    SAR_NEW  = 32'd0;
    DAR_NEW  = 32'd0;
    TCR_NEW  = 24'd0;
    TE_SET   = 2'b00;
    IRQ      = 2'b00;
    unique case (state)
      ST_IDLE: begin
        if (|req_ok) begin
          grant    = 1'b1;
          state_nx = ST_RD;
        end
      end
      ST_RD: begin
        BUS_REQ = 1'b1;
        BUS_A   = sar;
        BUS_BA  = lanes(ts, sar[1:0]);
        if (!BUS_BUSY)
          state_nx = ST_WR;
      end
      ST_WR: begin
        BUS_REQ = 1'b1;
        BUS_WE  = 1'b1;
        BUS_A   = dar;
        BUS_BA  = lanes(ts, dar[1:0]);
        BUS_DO  = data;
        if (!BUS_BUSY)
          state_nx = ST_UPD;
      end
      ST_UPD: begin
        UPD     = ch ? 2'b10 : 2'b01;
        SAR_NEW = step_addr(sm, ts, sar);
        DAR_NEW = step_addr(dm, ts, dar);
        TCR_NEW = tcr_new;
        TE_SET  = (tcr_new == 24'd0) ? UPD : 2'b00;
        IRQ     = TE_SET & IE;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmac_xfer_ctrl.sv
// Bench for dmac_xfer_ctrl: register-block stand-in, unit-level model
// checked every cycle, and directed scenarios with literal results.
module tb_dmac_xfer_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE  = 1'b1;
  logic [31:0] sar [2];
  logic [31:0] dar [2];
  logic [23:0] tcr [2];
  logic [1:0]  te;
  logic [1:0]  de = 0, ie = 0, ar = 0, dreq = 0;
  logic [1:0]  sm [2];
  logic [1:0]  dm [2];
  logic [1:0]  ts [2];
  logic        dme = 0, pr = 0, nmif = 0, ae = 0;
  logic        busy = 0;
  logic [31:0] di = 0;

  logic [31:0] BUS_A, BUS_DO, SAR_NEW, DAR_NEW;
  logic [3:0]  BUS_BA;
  logic        BUS_WE, BUS_REQ, ACT;
  logic [1:0]  UPD, TE_SET, IRQ;
  logic [23:0] TCR_NEW;

  dmac_xfer_ctrl dut (
    .CLK(CLK), .RST(RST), .CE(CE),
    .SAR0(sar[0]), .DAR0(dar[0]),
    .SAR1(sar[1]), .DAR1(dar[1]),
    .TCR0(tcr[0]), .TCR1(tcr[1]),
    .DE(de), .IE(ie), .TE(te), .AR(ar),
    .SM0(sm[0]), .DM0(dm[0]),
    .SM1(sm[1]), .DM1(dm[1]),
    .TS0(ts[0]), .TS1(ts[1]),
    .DME(dme), .PR(pr), .NMIF(nmif), .AE(ae),
    .DREQ(dreq),
    .BUS_A(BUS_A), .BUS_DO(BUS_DO),
    .BUS_DI(di), .BUS_BA(BUS_BA),
    .BUS_WE(BUS_WE), .BUS_REQ(BUS_REQ),
    .BUS_BUSY(busy), .UPD(UPD),
    .SAR_NEW(SAR_NEW), .DAR_NEW(DAR_NEW),
    .TCR_NEW(TCR_NEW), .TE_SET(TE_SET),
    .IRQ(IRQ), .ACT(ACT)
  );

  always #5 CLK = ~CLK;

  int vec  = 0;
  int errs = 0;

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  // Register-block stand-in.
  logic        cfg_load = 0;
  logic        c_n = 0;
  logic [31:0] c_sar = 0, c_dar = 0;
  logic [23:0] c_tcr = 0;

  always @(posedge CLK) begin
    if (cfg_load) begin
      sar[c_n] <= c_sar;
      dar[c_n] <= c_dar;
      tcr[c_n] <= c_tcr;
      te[c_n]  <= 1'b0;
    end else if (CE) begin
      for (int n = 0; n < 2; n++)
        if (UPD[n]) begin
          sar[n] <= SAR_NEW;
          dar[n] <= DAR_NEW;
          tcr[n] <= TCR_NEW;
          if (TE_SET[n]) te[n] <= 1'b1;
        end
    end
  end

  // Observed bus traffic and strobes.
  logic [31:0] tr_a  [$];
  logic        tr_we [$];
  logic [3:0]  tr_ba [$];
  logic [31:0] tr_do [$];
  int          units [$];
  int          irq_cnt [2] = '{0, 0};
  logic [1:0]  last_te_set = 0;

  always @(posedge CLK) begin
    if (CE && !RST) begin
      if (BUS_REQ && !busy) begin
        tr_a.push_back(BUS_A);
        tr_we.push_back(BUS_WE);
        tr_ba.push_back(BUS_BA);
        tr_do.push_back(BUS_DO);
      end
      for (int n = 0; n < 2; n++) begin
        if (UPD[n]) units.push_back(n);
        if (IRQ[n]) irq_cnt[n] <= irq_cnt[n] + 1;
      end
      if (|UPD) last_te_set <= TE_SET;
    end
  end

  // Unit-level model.
  function automatic logic [3:0] m_lanes(
    input logic [1:0] t, input logic [1:0] a);
    if (t == 0) return 4'(1 << (3 - int'(a)));
    if (t == 1) return a[1] ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_rep(
    input logic [1:0] t, input logic [1:0] a,
    input logic [31:0] d);
    logic [31:0] b;
    if (t == 0) begin
      b = (d >> (8 * (3 - int'(a)))) & 32'hFF;
      return b * 32'h01010101;
    end
    if (t == 1) begin
      b = a[1] ? (d & 32'hFFFF) : (d >> 16);
      return b * 32'h00010001;
    end
    return d;
  endfunction

  function automatic logic [31:0] m_next(
    input logic [1:0] md, input logic [1:0] t,
    input logic [31:0] a);
    int st;
    st = (t == 0) ? 1 : (t == 1) ? 2 : 4;
    if (md == 1) return a + st;
    if (md == 2) return a - st;
    return a;
  endfunction

  function automatic logic req_of(input int n);
    return de[n] && dme && !te[n] && !nmif && !ae
           && (ar[n] || dreq[n]);
  endfunction

  int          m_ph   = 0;
  logic        m_ch   = 0;
  logic        m_last = 1;
  logic [31:0] m_data = 0;

  function automatic logic pick();
    logic p;
    if (!pr) return req_of(0) ? 1'b0 : 1'b1;
    p = ~m_last;
    return req_of(int'(p)) ? p : ~p;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_ph   <= 0;
      m_last <= 1'b1;
      m_data <= 0;
    end else if (CE) begin
      case (m_ph)
        0: if (req_of(0) || req_of(1)) begin
          m_ch   <= pick();
          m_last <= pick();
          m_ph   <= 1;
        end
        1: if (!busy) begin
          m_data <= m_rep(ts[m_ch], sar[m_ch][1:0], di);
          m_ph   <= 2;
        end
        2: if (!busy) m_ph <= 3;
        default: m_ph <= 0;
      endcase
    end
  end

  // Per-cycle compare against the model.
  initial begin
    logic [31:0] ea;
    logic [3:0]  eba;
    logic [1:0]  eu, et;
    logic [23:0] etn;
    forever begin
      @(posedge CLK);
      #1;
      ea  = (m_ph == 1) ? sar[m_ch] :
            (m_ph == 2) ? dar[m_ch] : 0;
      eba = (m_ph == 1) ? m_lanes(ts[m_ch], sar[m_ch][1:0]) :
            (m_ph == 2) ? m_lanes(ts[m_ch], dar[m_ch][1:0]) : 0;
      eu  = (m_ph == 3) ? 2'(1 << m_ch) : 2'b00;
      etn = tcr[m_ch] - 1;
      et  = (m_ph == 3 && etn == 0) ? eu : 2'b00;
      check("act", ACT, m_ph != 0);
      check("req", BUS_REQ, m_ph == 1 || m_ph == 2);
      check("we", BUS_WE, m_ph == 2);
      check("addr", BUS_A, ea);
      check("ba", BUS_BA, eba);
      check("do", BUS_DO, (m_ph == 2) ? m_data : 0);
      check("upd", UPD, eu);
      check("te_set", TE_SET, et);
      check("irq", IRQ, et & ie);
      if (m_ph == 3) begin
        check("sar_new", SAR_NEW,
              m_next(sm[m_ch], ts[m_ch], sar[m_ch]));
        check("dar_new", DAR_NEW,
              m_next(dm[m_ch], ts[m_ch], dar[m_ch]));
        check("tcr_new", TCR_NEW, etn);
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge CLK);
  endtask

  task automatic load(
    input logic n, input logic [31:0] s,
    input logic [31:0] d, input logic [23:0] c);
    @(negedge CLK);
    c_n = n; c_sar = s; c_dar = d; c_tcr = c;
    cfg_load = 1;
    @(negedge CLK);
    cfg_load = 0;
  endtask

  task automatic wait_te(
    input logic [1:0] mask, input int maxc,
    input logic gate);
    int c = 0;
    while ((te & mask) != mask && c < maxc) begin
      @(negedge CLK);
      if (gate) CE = ~CE;
      c++;
    end
    CE = 1;
    check("te_wait", te & mask, mask);
  endtask

  int base, ub, ic, c;
  logic [31:0] a0;
  logic [3:0]  ba0;

  initial begin
    for (int n = 0; n < 2; n++) begin
      sm[n] = 0; dm[n] = 0; ts[n] = 0;
    end
    load(0, 0, 0, 0);
    load(1, 0, 0, 0);
    tick(1);
    check("rst_act", ACT, 0);
    check("rst_req", BUS_REQ, 0);
    check("rst_upd", UPD, 0);
    RST = 0;

    // Longword increment, two units, interrupt on end.
    ts[0] = 2; sm[0] = 1; dm[0] = 1;
    ie = 2'b01; ar = 2'b01; dme = 1;
    di = 32'hCAFE0001;
    load(0, 32'h1000, 32'h2000, 2);
    base = tr_a.size(); ic = irq_cnt[0];
    de = 2'b01;
    wait_te(2'b01, 40, 0);
    de = 0;
    tick(2);
    check("a_n", tr_a.size() - base, 4);
    check("a_r0", tr_a[base], 32'h1000);
    check("a_w0", tr_a[base+1], 32'h2000);
    check("a_r1", tr_a[base+2], 32'h1004);
    check("a_w1", tr_a[base+3], 32'h2004);
    check("a_we", {tr_we[base], tr_we[base+1]}, 2'b01);
    check("a_do", tr_do[base+1], 32'hCAFE0001);
    check("a_sar", sar[0], 32'h1008);
    check("a_dar", dar[0], 32'h2008);
    check("a_tcr", tcr[0], 0);
    check("a_tes", last_te_set, 2'b01);
    check("a_irq", irq_cnt[0] - ic, 1);

    // Byte lanes, decrementing destination.
    ts[0] = 0; sm[0] = 0; dm[0] = 2;
    di = 32'h1234565A;
    load(0, 32'h103, 32'h201, 1);
    base = tr_a.size();
    de = 2'b01;
    wait_te(2'b01, 20, 0);
    de = 0;
    tick(2);
    check("b_rba", tr_ba[base], 4'b0001);
    check("b_wba", tr_ba[base+1], 4'b0100);
    check("b_do", tr_do[base+1], 32'h5A5A5A5A);
    check("b_dar", dar[0], 32'h200);
    check("b_sar", sar[0], 32'h103);

    // Word lanes on channel 1 with CE toggling.
    ts[1] = 1; sm[1] = 1; dm[1] = 0;
    ar = 2'b10; di = 32'hABCD1234;
    load(1, 32'h302, 32'h400, 1);
    base = tr_a.size(); ub = units.size();
    ic = irq_cnt[1];
    de = 2'b10;
    wait_te(2'b10, 60, 1);
    de = 0;
    tick(2);
    check("f_rba", tr_ba[base], 4'b0011);
    check("f_wba", tr_ba[base+1], 4'b1100);
    check("f_do", tr_do[base+1], 32'h12341234);
    check("f_sar", sar[1], 32'h304);
    check("f_dar", dar[1], 32'h400);
    check("f_units", units.size() - ub, 1);
    check("f_irq", irq_cnt[1] - ic, 0);

    // Round robin from reset, then fixed priority.
    RST = 1;
    tick(1);
    RST = 0;
    pr = 1; ts[0] = 2; ts[1] = 2;
    sm[0] = 1; dm[0] = 1; sm[1] = 1; dm[1] = 1;
    ar = 2'b11;
    load(0, 32'h0, 32'h100, 2);
    load(1, 32'h200, 32'h300, 2);
    ub = units.size();
    de = 2'b11;
    wait_te(2'b11, 80, 0);
    de = 0;
    tick(2);
    check("rr_order",
          {units[ub][3:0], units[ub+1][3:0],
           units[ub+2][3:0], units[ub+3][3:0]},
          16'h0101);
    pr = 0;
    load(0, 32'h0, 32'h100, 2);
    load(1, 32'h200, 32'h300, 2);
    ub = units.size();
    de = 2'b11;
    wait_te(2'b11, 80, 0);
    de = 0;
    tick(2);
    check("fp_order",
          {units[ub][3:0], units[ub+1][3:0],
           units[ub+2][3:0], units[ub+3][3:0]},
          16'h0011);

    // Wait states in RD with master enable dropped.
    ar = 2'b01; busy = 1;
    load(0, 32'h500, 32'h600, 5);
    base = tr_a.size(); ub = units.size();
    de = 2'b01;
    c = 0;
    while (!BUS_REQ && c < 10) begin tick(1); c++; end
    check("d_start", BUS_REQ, 1);
    a0 = BUS_A; ba0 = BUS_BA;
    dme = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("d_a", BUS_A, a0);
      check("d_ba", BUS_BA, ba0);
      check("d_we", BUS_WE, 0);
    end
    busy = 0;
    c = 0;
    while (ACT && c < 20) begin tick(1); c++; end
    tick(10);
    check("d_idle", ACT, 0);
    check("d_units", units.size() - ub, 1);
    check("d_bus", tr_a.size() - base, 2);
    check("d_tcr", tcr[0], 4);
    de = 0; dme = 1;

    // NMI flag blocks arbitration.
    nmif = 1; de = 2'b01;
    tick(5);
    check("nmi_act", ACT, 0);
    de = 0; nmif = 0;

    // Reset during WR, then a zero count wraps.
    load(0, 32'h700, 32'h800, 3);
    ub = units.size();
    de = 2'b01;
    c = 0;
    while (!BUS_WE && c < 10) begin tick(1); c++; end
    check("e_wr", BUS_WE, 1);
    RST = 1;
    #1;
    check("e_req", BUS_REQ, 0);
    check("e_upd", UPD, 0);
    check("e_act", ACT, 0);
    de = 0;
    tick(1);
    RST = 0;
    tick(2);
    check("e_tcr", tcr[0], 3);
    check("e_units", units.size() - ub, 0);
    load(0, 32'h700, 32'h800, 0);
    de = 2'b01;
    c = 0;
    while (!UPD[0] && c < 10) begin tick(1); c++; end
    de = 0;
    check("e_upd0", UPD, 2'b01);
    check("e_tcrn", TCR_NEW, 24'hFFFFFF);
    check("e_tes", TE_SET, 0);
    tick(3);
    check("e_wrap", tcr[0], 24'hFFFFFF);
    check("e_te", te[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule

// File: doc/dmac_xfer_ctrl.md
DMAC_XFER_CTRL -- requirements
Module: dmac_xfer_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 CLK  in  1  sole clock; all state SHALL change on rising edge only.
REQ-003 RST  in  1  reset; asynchronous, active-high.
REQ-004 CE  in  1  clock enable; state advances only when CE=1.
REQ-005 SAR0,DAR0,SAR1,DAR1  in  32 each  channel source/destination addresses from the register block.
REQ-006 TCR0,TCR1  in  24 each  transfer counts.
REQ-007 DE,IE,TE,AR  in  2 each  per-channel enable, interrupt enable, transfer-end flag, auto-request; bit n = channel n.
REQ-008 SM0,DM0,SM1,DM1,TS0,TS1  in  2 each  source mode, destination mode, transfer size.
REQ-009 DME,PR,NMIF,AE  in  1 each  DMAOR master enable, priority mode, NMI flag, address-error flag.
REQ-010 DREQ  in  2  external request level per channel.
REQ-011 BUS_A  out  32  master address.
REQ-012 BUS_DO  out  32  write data.
REQ-013 BUS_DI  in  32  read data.
REQ-014 BUS_BA  out  4  byte-lane enables; BA[3] = bits 31:24.
REQ-015 BUS_WE, BUS_REQ  out  1 each  write strobe and cycle request.
REQ-016 BUS_BUSY  in  1  slave wait; the cycle completes on the first CE with BUS_REQ=1 and BUS_BUSY=0.
REQ-017 UPD  out  2  one-cycle strobe per channel; load SAR_NEW/DAR_NEW/TCR_NEW into that channel.
REQ-018 SAR_NEW, DAR_NEW  out  32 each; TCR_NEW  out  24.
REQ-019 TE_SET  out  2  one-cycle strobe; the channel's TE flag SHALL be set.
REQ-020 IRQ  out  2  one-cycle strobe, equal to TE_SET & IE.
REQ-021 ACT  out  1  high in any state other than IDLE.

Function
REQ-022 A channel SHALL request when DE[n] & DME & !TE[n] & !NMIF & !AE & (AR[n] | DREQ[n]).
REQ-023 Arbitration SHALL occur only in IDLE. With PR=0, channel 0 always wins. With PR=1, round-robin; the last-served pointer resets to channel 1, so channel 0 wins first.
REQ-024 States SHALL be IDLE -> RD -> WR -> UPD -> IDLE, one unit transfer per pass.
REQ-025 IDLE: on a winning request, latch the channel number and enter RD on the next CE; no request means stay in IDLE.
REQ-026 RD: BUS_REQ=1, BUS_WE=0, BUS_A=SAR. On completion, latch BUS_DI and go to WR.
REQ-027 WR: BUS_REQ=1, BUS_WE=1, BUS_A=DAR, BUS_DO=latched data replicated (byte to all 4 lanes, word to both halves). On completion, go to UPD.
REQ-028 BUS_A, BUS_WE and BUS_BA SHALL stay stable while BUSY=1.
REQ-029 Byte lanes SHALL be: TS=00 byte, BA[3-A[1:0]]; TS=01 word, A[1]=0 gives 1100, A[1]=1 gives 0011; TS=10/11 long, 1111.
REQ-030 For the byte and word read paths, the selected lane SHALL be extracted before replication.
REQ-031 UPD SHALL assert UPD[ch] for exactly one CE.
REQ-032 Address step SHALL be 1/2/4 for TS=00/01/10; TS=11 is treated as longword.
REQ-033 SM/DM address modes: 00 fixed, 01 +step, 10 -step, 11 fixed; arithmetic is modulo 2^32.
REQ-034 TCR_NEW = TCR-1 modulo 2^24; TCR=0 at start yields FFFFFF, i.e. 2^24 transfers.
REQ-035 If TCR_NEW=0, TE_SET[ch] and IRQ[ch] (if IE) SHALL pulse in the same cycle as UPD.
REQ-036 DME, DE, NMIF or AE deasserting mid-unit SHALL NOT abort the unit. The unit completes through UPD, then no further unit starts.
REQ-037 TE inputs SHALL be sampled in IDLE only, so TE set by UPD blocks the next arbitration.
REQ-038 When CE=0, all outputs SHALL hold and strobes SHALL NOT repeat.
REQ-039 Idle output values: BUS_REQ=0, BUS_WE=0, BUS_BA=0000, BUS_A=0, BUS_DO=0, and UPD/TE_SET/IRQ=0.

Reset
REQ-040 RST=1 SHALL force IDLE immediately (asynchronously), including mid-cycle: outputs go to REQ-039 values, latched data clears, and the round-robin pointer is set to channel 1.
REQ-041 After RST falls, the first arbitration SHALL occur on the next CE.

Verification
REQ-042 Ch0: AR=1, TS=10, SM=DM=01, SAR=1000, DAR=2000, TCR=2, BUSY=0 -> reads 1000 then 1004, writes 2000 then 2004. Final strobe gives TCR_NEW=0, SAR_NEW=1008, DAR_NEW=2008, TE_SET[0]=1, and IRQ[0] if IE.
REQ-043 Byte: SAR=...03, DI=xxxxxx5A, DAR=...01, DM=10 -> BA read 0001, write BA 0100, DO=5A5A5A5A, DAR_NEW=...00.
REQ-044 Both channels auto-request, PR=1 -> unit order 0,1,0,1. With PR=0 -> channel 0 runs until TE, then channel 1 runs.
REQ-045 BUSY held 3 CEs in RD and DME cleared during it -> address stable throughout; the unit completes with one UPD, then IDLE and no further requests issued.
REQ-046 RST pulsed during WR -> BUS_REQ=0 the same cycle with no UPD; after release with TCR=0 loaded, the count wraps to FFFFFF and TE_SET stays 0.
